wb_ctrl: RTL
============

Name: wb_ctrl

Overview:
- Writeback-side driver of the register-file write port (w_ena/w_addr/w_data).
- Merges two write sources:
  - in-order pipeline results from MEM;
  - out-of-order results from a long-latency unit (divider/multi-cycle load), buffered in a small FIFO.
- Keeps a per-register busy scoreboard and gives ID a stall when an instruction touches a register with a pending long-latency write.
- Sits between MEM/long-latency unit and regs; stall goes to ID.

Parameters:
- DEPTH, 4, long-latency result FIFO entries; power of two, >= 2.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk_100MHz  input  1  core clock, all state on rising edge.
- arst  input  1  asynchronous reset, active-high.
- mem_w_ena_i  input  1  pipeline result valid this cycle; cannot be back-pressured.
- mem_w_addr_i  input  ADDR_W  pipeline destination register.
- mem_w_data_i  input  DATA_W  pipeline result.
- lu_valid_i  input  1  long-latency result offered.
- lu_addr_i  input  ADDR_W  long-latency destination register.
- lu_data_i  input  DATA_W  long-latency result.
- lu_ready_o  output  1  FIFO can accept; a transfer occurs when lu_valid_i && lu_ready_o.
- lu_issue_i  input  1  ID issues a long-latency op this cycle.
- lu_issue_addr_i  input  ADDR_W  destination of the issued op.
- id_rs1_addr_i  input  ADDR_W  ID source 1.
- id_rs2_addr_i  input  ADDR_W  ID source 2.
- id_rd_addr_i  input  ADDR_W  ID destination.
- stall_o  output  1  ID must hold; combinational from the scoreboard register.
- w_ena_o  output  1  register-file write enable, registered.
- w_addr_o  output  ADDR_W  register-file write address, registered.
- w_data_o  output  DATA_W  register-file write data, registered.
- busy_o  output  1  any scoreboard bit set or FIFO non-empty.

Behaviour:
- Reset (arst high, asynchronous): all outputs 0; FIFO emptied; scoreboard cleared; lu_ready_o = 1 after reset deasserts.
  - Reset mid-operation drops all buffered results and pending bits without producing writes.
- Output register: each cycle the selected source is loaded into w_ena_o/w_addr_o/w_data_o. If no source is selected, w_ena_o = 0 and addr/data hold their previous values.
- Arbitration priority:
  1. mem_w_ena_i: latency 1 cycle from input to w_ena_o.
  2. FIFO head: popped only in cycles with mem_w_ena_i = 0.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count 0..DEPTH; pointers wrap modulo DEPTH.
  - Push on lu_valid_i && lu_ready_o.
  - lu_ready_o = (count != DEPTH); it is registered-state based, not dependent on same-cycle pop.
  - Pop reads only stored entries. An accepted lu result reaches w_ena_o no earlier than 2 cycles after acceptance.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pop on an empty FIFO never occurs.
- x0 handling:
  - Any write to address 0 from either source is dropped: w_ena_o = 0 that cycle, and a FIFO entry is still popped.
  - lu_issue_i with address 0 never sets a bit.
- Scoreboard: ADDR_W-indexed busy vector, 2**ADDR_W bits.
  - Set on lu_issue_i for lu_issue_addr_i.
  - Cleared in the cycle its FIFO entry is popped, i.e. when the write is loaded into the output register.
  - Same-cycle set and clear of the same bit: set wins.
- Stall:
  - stall_o = busy[rs1] | busy[rs2] | busy[rd], each term masked when its address is 0.
  - stall_o deasserts the cycle after the clearing pop. The write is then visible to regs on that same edge (regs bypasses w_data), so no extra bubble is needed.
- Invariant: a pipeline write to a busy register cannot occur, because ID stalls on a busy rd.
  - Bench asserts: mem_w_ena_i && busy[mem_w_addr_i] never true.
- busy_o = |scoreboard | (count != 0).

Test Plan:
- Pipeline only: mem_w_ena_i = 1, addr = 5, data = 0x1234 at cycle N -> w_ena_o = 1, w_addr_o = 5, w_data_o = 0x1234 at N+1; cycle N+1 with no input -> w_ena_o = 0.
- Long op round trip:
  - lu_issue_i addr = 7 -> id_rs1_addr_i = 7 gives stall_o = 1.
  - lu result 0xDEAD accepted at M with no pipeline traffic -> w_ena_o/addr 7/0xDEAD at M+2; stall_o = 0 at M+3; busy_o = 0.
- Contention: lu result addr 3 accepted, then mem_w_ena_i held high 4 cycles -> FIFO entry stays; addr 3 written the first cycle after mem_w_ena_i drops; pipeline writes appear in order with 1-cycle latency.
- Full FIFO: issue 4 ops (addrs 1-4), push 4 results with mem_w_ena_i held high -> lu_ready_o = 0 after the 4th push; 5th lu_valid_i not accepted; drain order 1, 2, 3, 4; pointers wrap correctly on a following 4-entry burst.
- x0: mem_w_ena_i with addr 0, and an lu result with addr 0 -> w_ena_o never 1; lu_issue_i addr 0 -> stall_o stays 0.
- Reset mid-operation: 2 entries in FIFO plus 2 busy bits, assert arst asynchronously between edges -> outputs 0 immediately, busy_o = 0, no writes after release, lu_ready_o = 1.

Source files
------------

// File: rtl/wb_ctrl.sv
// Writeback controller: merges in-order MEM results with buffered long-latency
// results onto the register-file write port and tracks pending long-latency writes.
module wb_ctrl #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_100MHz,
    input  logic              arst,
    input  logic              mem_w_ena_i,
    input  logic [ADDR_W-1:0] mem_w_addr_i,
    input  logic [DATA_W-1:0] mem_w_data_i,
    input  logic              lu_valid_i,
    input  logic [ADDR_W-1:0] lu_addr_i,
    input  logic [DATA_W-1:0] lu_data_i,
    output logic              lu_ready_o,
    input  logic              lu_issue_i,
    input  logic [ADDR_W-1:0] lu_issue_addr_i,
    input  logic [ADDR_W-1:0] id_rs1_addr_i,
    input  logic [ADDR_W-1:0] id_rs2_addr_i,
    input  logic [ADDR_W-1:0] id_rd_addr_i,
    output logic              stall_o,
    output logic              w_ena_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic [DATA_W-1:0] w_data_o,
    output logic              busy_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_W;

    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [ADDR_W-1:0] X0       = {ADDR_W{1'b0}};
    localparam logic [NREG-1:0]   ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [NREG-1:0]   r_busy;
    logic              r_w_ena;
    logic [ADDR_W-1:0] r_w_addr;
    logic [DATA_W-1:0] r_w_data;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [NREG-1:0]   w_clr_mask;
    logic [NREG-1:0]   w_set_mask;
    logic [NREG-1:0]   w_busy_nxt;
    logic              w_sel_ena;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_rs1_busy;
    logic              w_rs2_busy;
    logic              w_rd_busy;

    assign w_full      = (r_count == CNT_FULL);
    assign w_empty     = (r_count == CNT_ZERO);
    // Ready is held low while reset is applied so every output reads 0 in reset.
    assign lu_ready_o  = ~arst & ~w_full;
    assign w_push      = lu_valid_i & ~w_full;
    assign w_pop       = ~mem_w_ena_i & ~w_empty;
    assign w_head_addr = r_fifo_addr[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk_100MHz) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= lu_addr_i;
            r_fifo_data[r_wptr] <= lu_data_i;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_100MHz or posedge arst) begin
        if (arst) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= CNT_ZERO;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Scoreboard next state: set applied after clear so a same-cycle set wins.
    always_comb begin
        w_clr_mask = (w_pop && (w_head_addr != X0)) ? (ONE_HOT0 << w_head_addr) : {NREG{1'b0}};
        w_set_mask = (lu_issue_i && (lu_issue_addr_i != X0)) ? (ONE_HOT0 << lu_issue_addr_i) : {NREG{1'b0}};
        w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
    end

    // Scoreboard register.
    always_ff @(posedge clk_100MHz or posedge arst) begin
        if (arst) begin
            r_busy <= {NREG{1'b0}};
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Source select: pipeline first, FIFO head otherwise; writes to x0 are dropped.
    always_comb begin
        w_sel_ena  = 1'b0;
        w_sel_addr = r_w_addr;
        w_sel_data = r_w_data;
        if (mem_w_ena_i) begin
            if (mem_w_addr_i != X0) begin
                w_sel_ena  = 1'b1;
                w_sel_addr = mem_w_addr_i;
                w_sel_data = mem_w_data_i;
            end else begin
                w_sel_ena  = 1'b0;
            end
        end else if (w_pop) begin
            if (w_head_addr != X0) begin
                w_sel_ena  = 1'b1;
                w_sel_addr = w_head_addr;
                w_sel_data = w_head_data;
            end else begin
                w_sel_ena  = 1'b0;
            end
        end else begin
            w_sel_ena  = 1'b0;
        end
    end

    // Register-file write port register.
    always_ff @(posedge clk_100MHz or posedge arst) begin
        if (arst) begin
            r_w_ena  <= 1'b0;
            r_w_addr <= X0;
            r_w_data <= {DATA_W{1'b0}};
        end else begin
            r_w_ena  <= w_sel_ena;
            r_w_addr <= w_sel_addr;
            r_w_data <= w_sel_data;
        end
    end

    assign w_rs1_busy = (id_rs1_addr_i != X0) & r_busy[id_rs1_addr_i];
    assign w_rs2_busy = (id_rs2_addr_i != X0) & r_busy[id_rs2_addr_i];
    assign w_rd_busy  = (id_rd_addr_i  != X0) & r_busy[id_rd_addr_i];

    assign stall_o  = w_rs1_busy | w_rs2_busy | w_rd_busy;
    assign busy_o   = (|r_busy) | ~w_empty;
    assign w_ena_o  = r_w_ena;
    assign w_addr_o = r_w_addr;
    assign w_data_o = r_w_data;

endmodule
